// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port req/gnt arbiter and sequencer for a synchronous-read byte memory.
// Define MEM_ARB_RR_EN for round-robin selection; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned DEPTH = 1025
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [7:0]  p0_rdata,
    output logic [7:0]  p1_rdata,
    output logic        p0_err,
    output logic        p1_err,
    output logic        mem_ce,
    output logic        mem_wre,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [1:0][7:0] rdata_q, rdata_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic [1:0]      err_q, err_d;
    logic            idle, sel1, any_gnt;
    logic            sel_we;
    logic [15:0]     sel_addr;
    logic [7:0]      sel_wdata;
`ifdef MEM_ARB_RR_EN
    logic            last_q, last_d;
`endif

    // Handshake: a requester holds req high with stable fields; the transaction is
    // accepted at the rising edge where its gnt is high (only ever in IDLE).
    assign idle = (state_q == S_IDLE);
`ifdef MEM_ARB_RR_EN
    assign sel1 = p1_req & (~p0_req | ~last_q);
`else
    assign sel1 = p1_req & ~p0_req;
`endif
    assign p0_gnt    = idle & p0_req & ~sel1;
    assign p1_gnt    = idle & sel1;
    assign any_gnt   = p0_gnt | p1_gnt;
    assign sel_we    = sel1 ? p1_we    : p0_we;
    assign sel_addr  = sel1 ? p1_addr  : p0_addr;
    assign sel_wdata = sel1 ? p1_wdata : p0_wdata;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 2'b00;
        err_d    = 2'b00;
`ifdef MEM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_gnt) begin
                    owner_d = p1_gnt;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
`ifdef MEM_ARB_RR_EN
                    last_d  = p1_gnt;
`endif
                    if ({16'd0, sel_addr} >= DEPTH) state_d = S_ERR;
                    else if (sel_we)                state_d = S_WR;
                    else                            state_d = S_RD_ADDR;
                end
            end
            S_WR:      state_d = S_IDLE;
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: begin
                rdata_d[owner_q]  = mem_rdata;
                rvalid_d[owner_q] = 1'b1;
                state_d           = S_IDLE;
            end
            S_ERR: begin
                // Out-of-range writes are dropped; reads still complete with zero data.
                err_d[owner_q] = 1'b1;
                if (!we_q) begin
                    rvalid_d[owner_q] = 1'b1;
                    rdata_d[owner_q]  = 8'h00;
                end
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
`ifdef MEM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
`ifdef MEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign mem_ce    = (state_q == S_WR) | (state_q == S_RD_ADDR) | (state_q == S_RD_DATA);
    assign mem_wre   = (state_q == S_WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_rdata  = rdata_q[0];
    assign p1_rdata  = rdata_q[1];
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction vector table plus hand-written
// sequences for arbitration, back-to-back timing and mid-transaction reset.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [7:0]  p0_rdata, p1_rdata;
    logic        mem_ce, mem_wre;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_q;
    logic [2:0]  dbg_state;
    logic [7:0]  mem_arr [0:1024];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_err(p0_err), .p1_err(p1_err),
        .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_q), .dbg_state(dbg_state)
    );

    // Synchronous-read byte memory model.
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wre) mem_arr[mem_addr] <= mem_wdata;
            else         mem_q <= mem_arr[mem_addr];
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          exp_ce;
        int          exp_wre;
        int          exp_rv_cyc;
        logic [7:0]  exp_rdata;
        int          exp_err_cyc;
    } vec_t;

    vec_t vecs [10];
    logic [0:0] exp_q [$];

    function automatic vec_t mk(bit port, bit we, logic [15:0] a, logic [7:0] d,
                                int ce, int wre, int rv, logic [7:0] rd, int er);
        vec_t v;
        v.port = port; v.we = we; v.addr = a; v.wdata = d;
        v.exp_ce = ce; v.exp_wre = wre; v.exp_rv_cyc = rv; v.exp_rdata = rd;
        v.exp_err_cyc = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit port, input logic req, input logic we,
                         input logic [15:0] addr, input logic [7:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    // Issue one transaction; cycle 0 is the grant cycle, then observe 8 more cycles.
    task automatic run_txn(input vec_t v, input string tag);
        int wait_n, ce_n, wre_n, rv_n, rv_cyc, err_n, err_cyc, other_n;
        bit granted;
        logic [7:0] rd;
        ce_n = 0; wre_n = 0; rv_n = 0; rv_cyc = 0; err_n = 0; err_cyc = 0;
        other_n = 0; granted = 0; rd = 8'h00; wait_n = 0;
        @(posedge clk); #1;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        forever begin
            @(negedge clk);
            if ((v.port ? p1_gnt : p0_gnt) === 1'b1) begin
                granted = 1;
                break;
            end
            if (wait_n == 20) break;
            wait_n++;
        end
        chk({tag, "_granted"}, {31'd0, granted}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) drive(v.port, 1'b0, v.we, v.addr, v.wdata);
            @(negedge clk);
            if (mem_ce)  ce_n++;
            if (mem_ce && mem_wre) wre_n++;
            if ((v.port ? p1_rvalid : p0_rvalid) === 1'b1) begin
                rv_n++;
                if (rv_cyc == 0) begin
                    rv_cyc = k;
                    rd = v.port ? p1_rdata : p0_rdata;
                end
            end
            if ((v.port ? p1_err : p0_err) === 1'b1) begin
                err_n++;
                if (err_cyc == 0) err_cyc = k;
            end
            if ((v.port ? p0_rvalid : p1_rvalid) !== 1'b0) other_n++;
            if ((v.port ? p0_err : p1_err) !== 1'b0) other_n++;
        end
        chk({tag, "_ce_cycles"}, ce_n, v.exp_ce);
        chk({tag, "_wre_cycles"}, wre_n, v.exp_wre);
        chk({tag, "_rvalid_count"}, rv_n, (v.exp_rv_cyc != 0) ? 1 : 0);
        chk({tag, "_rvalid_cycle"}, rv_cyc, v.exp_rv_cyc);
        if (!v.we) chk({tag, "_rdata"}, {24'd0, rd}, {24'd0, v.exp_rdata});
        chk({tag, "_err_count"}, err_n, (v.exp_err_cyc != 0) ? 1 : 0);
        chk({tag, "_err_cycle"}, err_cyc, v.exp_err_cyc);
        chk({tag, "_other_port_quiet"}, other_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc;
        logic [6:0] e_g0, e_g1, e_rv0;
        for (int i = 0; i <= 1024; i++) mem_arr[i] = 8'h00;
        mem_q = 8'h00;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        chk("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
        chk("rst_mem_wre", {31'd0, mem_wre}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_outputs", {p0_rvalid, p1_rvalid, p0_err, p1_err, p0_rdata, p1_rdata}, 32'd0);
        #2 rst = 1'b1;

        vecs[0] = mk(0, 1, 16'h0010, 8'hA5, 1, 1, 0, 8'h00, 0);
        vecs[1] = mk(0, 0, 16'h0010, 8'h00, 2, 0, 3, 8'hA5, 0);
        vecs[2] = mk(1, 1, 16'h0401, 8'h55, 0, 0, 0, 8'h00, 2);
        vecs[3] = mk(1, 0, 16'hFFFF, 8'h00, 0, 0, 2, 8'h00, 2);
        vecs[4] = mk(1, 1, 16'h0400, 8'h3C, 1, 1, 0, 8'h00, 0);
        vecs[5] = mk(0, 0, 16'h0400, 8'h00, 2, 0, 3, 8'h3C, 0);
        vecs[6] = mk(0, 0, 16'h0401, 8'h00, 0, 0, 2, 8'h00, 2);
        vecs[7] = mk(1, 1, 16'h0000, 8'h7E, 1, 1, 0, 8'h00, 0);
        vecs[8] = mk(1, 0, 16'h0000, 8'h00, 2, 0, 3, 8'h7E, 0);
        vecs[9] = mk(1, 0, 16'h0010, 8'h00, 2, 0, 3, 8'hA5, 0);
        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Both ports reading continuously
`ifdef MEM_ARB_RR_EN
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        drive(1, 1'b1, 1'b0, 16'h0000, 8'h00);
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            chk("arb_single_grant", {31'd0, p0_gnt & p1_gnt}, 32'd0);
            if (p0_gnt | p1_gnt) begin
                chk($sformatf("arb_grant%0d", n), {31'd0, p1_gnt}, {31'd0, exp_q.pop_front()});
                n++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        chk("arb_grant_count", n, 4);
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        repeat (6) @(negedge clk);

        // Back-to-back: p0 write, p0 read, p1 write
        e_g0 = 7'b0000101; e_g1 = 7'b0100000; e_rv0 = 7'b0100000;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive(0, 1'b1, 1'b1, 16'h0020, 8'h11);
            if (c == 1) drive(0, 1'b1, 1'b0, 16'h0020, 8'h00);
            if (c == 3) begin
                drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
                drive(1, 1'b1, 1'b1, 16'h0030, 8'h22);
            end
            if (c == 6) drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
            @(negedge clk);
            chk($sformatf("b2b_p0_gnt_c%0d", c), {31'd0, p0_gnt}, {31'd0, e_g0[c]});
            chk($sformatf("b2b_p1_gnt_c%0d", c), {31'd0, p1_gnt}, {31'd0, e_g1[c]});
            chk($sformatf("b2b_p0_rvalid_c%0d", c), {31'd0, p0_rvalid}, {31'd0, e_rv0[c]});
            if (c == 5) chk("b2b_p0_rdata", {24'd0, p0_rdata}, 32'h11);
            if (c == 6) chk("b2b_p1_write", {mem_ce, mem_wre, mem_addr, mem_wdata}, {2'b11, 16'h0030, 8'h22});
        end
        repeat (3) @(negedge clk);
        chk("b2b_mem_written", {24'd0, mem_arr[16'h0030]}, 32'h22);

        // Reset during RD_DATA
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        @(negedge clk);
        chk("rstmid_gnt", {31'd0, p0_gnt}, 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(posedge clk); #1;
        chk("rstmid_in_rd_data", {29'd0, dbg_state, mem_ce}, 32'h7);
        rst = 1'b0;
        #1;
        chk("rstmid_ce_async", {31'd0, mem_ce}, 32'd0);
        chk("rstmid_state", {29'd0, dbg_state}, 32'd0);
        chk("rstmid_mem_regs", {mem_wre, mem_addr, mem_wdata}, 32'd0);
        chk("rstmid_outputs", {p0_rvalid, p1_rvalid, p0_err, p1_err, p0_rdata, p1_rdata}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rstmid_no_resp%0d", k), {p0_rvalid, p0_err, mem_ce}, 32'd0);
        end
        run_txn(mk(0, 0, 16'h0010, 8'h00, 2, 0, 3, 8'hA5, 0), "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-ported byte memory. It lets two requesters share the memory's `ce`/`wre` interface: port 0 is the CPU load/store/fetch unit and port 1 is the loader/DMA engine. It drives the memory's synchronous-read timing, so requesters see a simple req/gnt/rvalid protocol. It also blocks out-of-range addresses before they reach the memory array.

## Interface
Parameters:
- `DEPTH`, default 1025: number of valid byte addresses (0 .. DEPTH-1). Any address >= DEPTH is out of range.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset; one clock, asynchronous, active-low.
- `p0_req`, `p1_req`  input  1  request; hold high, with fields stable, until `pX_gnt`.
- `p0_we`, `p1_we`  input  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  input  16  byte address.
- `p0_wdata`, `p1_wdata`  input  8  write data.
- `p0_gnt`, `p1_gnt`  output  1  combinational; request accepted at this rising edge.
- `p0_rvalid`, `p1_rvalid`  output  1  one-cycle pulse; `pX_rdata` is valid.
- `p0_rdata`, `p1_rdata`  output  8  read data; held until the next read completes on that port.
- `p0_err`, `p1_err`  output  1  one-cycle pulse; the transaction was out of range.
- `mem_ce`, `mem_wre`  output  1  memory chip enable and write enable.
- `mem_addr`  output  16  memory address.
- `mem_wdata`  output  8  memory write data.
- `mem_rdata`  input  8  memory read data; valid only while `mem_ce & !mem_wre`.

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_DATA, ERR.
- **IDLE:**
  - `pX_gnt = pX_req & selected(X)`; at most one grant per cycle.
  - At the granting edge, latch owner, `we`, `addr` and `wdata`.
  - Next state:
    - ERR if `addr >= DEPTH`.
    - Otherwise WR if `we`.
    - Otherwise RD_ADDR.
- **WR:** `mem_ce=1`, `mem_wre=1`, latched addr/wdata driven. Memory writes at the exiting edge. Next state IDLE. No response pulse.
- **RD_ADDR:** `mem_ce=1`, `mem_wre=0`. The memory registers the array data at the exiting edge. Next state RD_DATA.
- **RD_DATA:** `mem_ce=1`, `mem_wre=0`, same address. At the exiting edge: `owner_rdata <= mem_rdata`, `owner_rvalid <= 1`. Next state IDLE.
- **ERR:** `mem_ce=0`. At the exiting edge: `owner_err <= 1`. For a read, also `owner_rvalid <= 1` and `owner_rdata <= 8'h00`. A write is dropped. Next state IDLE.
- `mem_ce`/`mem_wre` are decoded from the state register only, so they are glitch-free.
- `mem_addr`/`mem_wdata` come from the latched registers and hold their last value in IDLE.
- Selection is governed by `MEM_ARB_RR_EN` (see Configuration).
- The arbiter never drives the memory's own reset.

## Timing
- Grant decision is combinational; acceptance happens at the rising edge where `pX_gnt=1`.
- Write: gnt in cycle 0, memory write at the end of cycle 1, next grant possible in cycle 2.
- Read: gnt in cycle 0, RD_ADDR in cycle 1, RD_DATA in cycle 2, `rvalid`/`rdata` in cycle 3. Latency is 3 cycles. A new grant is possible in cycle 3, so a read response and the next grant can coincide.
- Out of range: gnt in cycle 0, ERR in cycle 1, `err` (plus `rvalid` for a read) in cycle 2.
- `pX_gnt` is always 0 outside IDLE; requesters keep `req` high while waiting.
- Reset values:
  - State IDLE.
  - `mem_ce=0`, `mem_wre=0`, `mem_addr=0`, `mem_wdata=0`.
  - All `rdata=8'h00`, all `rvalid=0`, all `err=0`.
  - Round-robin pointer favours port 0.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately and `mem_ce` drops asynchronously.
  - The pending transaction is discarded with no `rvalid` or `err`.
  - A WR aborted before its exiting edge does not write.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - When both ports request, the port not granted most recently wins.
  - The pointer updates on every grant, including ERR grants.
  - A single requester always wins.
- `MEM_ARB_RR_EN` undefined: fixed priority. Port 0 wins whenever `p0_req=1`, and no pointer is built.

## Test plan
- Reset, then p0 write addr 16'h0010 data 8'hA5, then p0 read 16'h0010. Expect `mem_ce=1`, `mem_wre=1` for exactly 1 cycle, then `p0_rvalid` 3 cycles after the read gnt with `p0_rdata=8'hA5`.
- p0 read and p1 read both asserted continuously from IDLE. With `MEM_ARB_RR_EN`, expect grants p0, p1, p0, p1. Without it, expect p0 every time and p1 never.
- p1 write to 16'h0401 and p1 read to 16'hFFFF with DEPTH=1025. Expect `mem_ce` stays 0 and `p1_err` pulses for both. For the read, `p1_rvalid=1` with `p1_rdata=8'h00`.
- Back-to-back: p0 write, then p0 read, then p1 write, with `req` held. Expect gnts at cycles 0, 2 and 5, and `p0_rvalid` at cycle 5 coinciding with `p1_gnt`.
- Assert `rst` low during RD_DATA. Expect `mem_ce=0` immediately, no `rvalid`, and all outputs at reset values. After release, a fresh p0 read completes normally.
